ifetch: RTL and testbench

IFETCH -- requirements
Module: ifetch

---
 rtl/rv32_pkg.sv | 14 +
 rtl/ifetch_fifo.sv | 59 +++++
 rtl/ifetch.sv | 131 +++++++++++++
 tb/tb_ifetch.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32_pkg.sv
// Shared RV32 definitions for the fetch front end: word size, canonical NOP
// and the fetch FSM state encoding.
package rv32_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSN = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/ifetch_fifo.sv
// Small circular FIFO with synchronous flush, used both as the decode-side
// instruction buffer and as the queue of PCs for fetches still in flight.
module ifetch_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;

    // Pointers wrap explicitly so non-power-of-two depths work.
    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= bump(wr_ptr);
            if (do_pop)  rd_ptr <= bump(rd_ptr);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/ifetch.sv
// Instruction fetch stage: issues word fetches from the PC, buffers returned
// instructions for decode, and discards stale responses after a redirect.
module ifetch
    import rv32_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        ins_valid,
    output logic [31:0] ins,
    output logic [31:0] ins_pc,
    input  logic        ins_ready
);

    localparam int CW = $clog2(DEPTH + 1);

    fetch_state_t    state, state_next;
    logic [XLEN-1:0] pc, pc_next;
    logic [CW-1:0]   discard, discard_next;
    logic [XLEN-1:0] redirect_target;

    logic            req_fire;
    logic            rsp_accept;
    logic [CW:0]     in_use;

    logic            inf_full, inf_empty;
    logic [CW-1:0]   inf_count;
    logic [XLEN-1:0] inf_head;

    logic            buf_push, buf_pop;
    logic            buf_full, buf_empty;
    logic [CW-1:0]   buf_count;
    logic [2*XLEN-1:0] buf_head;

    assign redirect_target = redirect_pc & 32'hFFFF_FFFC;

    // A slot freed by this cycle's decode pop is credited immediately, which
    // keeps one instruction per cycle at steady state without ever overfilling.
    assign buf_pop  = ins_valid && ins_ready;
    assign in_use   = {1'b0, inf_count} + {1'b0, buf_count} - (CW+1)'(buf_pop);

    assign imem_req_valid = (state == RUN) && !redirect_valid && !inf_full
                            && (in_use < (CW+1)'(DEPTH));
    assign imem_req_addr  = pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign rsp_accept = imem_rsp_valid && (state == RUN) && !redirect_valid && !inf_empty;
    assign buf_push   = rsp_accept && (!buf_full || buf_pop);

    ifetch_fifo #(.WIDTH(XLEN), .DEPTH(DEPTH)) u_inflight (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_valid),
        .push      (req_fire),
        .push_data (pc),
        .pop       (rsp_accept),
        .head      (inf_head),
        .full      (inf_full),
        .empty     (inf_empty),
        .count     (inf_count)
    );

    ifetch_fifo #(.WIDTH(2*XLEN), .DEPTH(DEPTH)) u_ibuf (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_valid),
        .push      (buf_push),
        .push_data ({imem_rsp_data, inf_head}),
        .pop       (buf_pop),
        .head      (buf_head),
        .full      (buf_full),
        .empty     (buf_empty),
        .count     (buf_count)
    );

    assign ins_valid = !buf_empty;
    assign ins       = buf_empty ? NOP_INSN : buf_head[2*XLEN-1:XLEN];
    assign ins_pc    = buf_empty ? '0 : buf_head[XLEN-1:0];

    // Next-state logic; a redirect counts every fetch still owed by memory,
    // minus a response landing this cycle (it is dropped here directly).
    always_comb begin
        state_next   = state;
        pc_next      = pc;
        discard_next = discard;
        case (state)
            IDLE: begin
                state_next = RUN;
                if (redirect_valid) pc_next = redirect_target;
            end
            RUN: begin
                if (redirect_valid) begin
                    pc_next      = redirect_target;
                    discard_next = inf_count - CW'(imem_rsp_valid && !inf_empty)
                                   + CW'(req_fire);
                    state_next   = (discard_next != '0) ? FLUSH : RUN;
                end else if (req_fire) begin
                    pc_next = pc + 32'd4;
                end
            end
            FLUSH: begin
                if (redirect_valid) pc_next = redirect_target;
                if (imem_rsp_valid && discard != '0) discard_next = discard - 1'b1;
                if (discard_next == '0) state_next = RUN;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            pc      <= RESET_PC;
            discard <= '0;
        end else begin
            state   <= state_next;
            pc      <= pc_next;
            discard <= discard_next;
        end
    end

endmodule

// File: tb/tb_ifetch.sv
// Directed bench for ifetch: behavioural memory with programmable latency,
// expected-instruction scoreboard and a negedge monitor.
module tb_ifetch;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DEPTH    = 2;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        ins_valid;
    logic [31:0] ins;
    logic [31:0] ins_pc;
    logic        ins_ready;

    typedef struct packed {
        logic [31:0] addr;
        int          due;
    } mem_req_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
    } exp_ins_t;

    mem_req_t    mem_q[$];
    exp_ins_t    sb[$];
    int          pop_cycles[$];
    int          cyc;
    int          lat;
    int          fire_count;
    logic [31:0] last_fire_addr;
    int          n_checks;
    int          n_fail;

    ifetch #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .ins_valid      (ins_valid),
        .ins            (ins),
        .ins_pc         (ins_pc),
        .ins_ready      (ins_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc++;

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        case (addr)
            32'h0: return 32'h0070_0093;
            32'h4: return 32'h00C0_0113;
            32'h8: return 32'h0020_81B3;
            default: return addr ^ 32'h1234_5678;
        endcase
    endfunction

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic expect_ins(input logic [31:0] pc);
        sb.push_back('{pc: pc, data: mem_word(pc)});
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic run_until_fires(input int target, input string name);
        int budget;
        budget = 60;
        while (fire_count < target && budget > 0) begin
            @(posedge clk);
            #1;
            budget--;
        end
        n_checks++;
        if (fire_count < target) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d fetches, expected %0d", name, fire_count, target);
        end
    endtask

    task automatic apply_stimulus(input logic rdy, input logic irdy, input int l);
        imem_req_ready = rdy;
        ins_ready      = irdy;
        lat            = l;
    endtask

    task automatic pulse_redirect(input logic [31:0] target);
        redirect_valid = 1'b1;
        redirect_pc    = target;
        #1;
        check_output("req_valid_during_redirect", {31'd0, imem_req_valid}, 32'd0);
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_output({tag, "_req_valid"}, {31'd0, imem_req_valid}, 32'd0);
        check_output({tag, "_ins_valid"}, {31'd0, ins_valid}, 32'd0);
        check_output({tag, "_ins"}, ins, NOP);
        check_output({tag, "_ins_pc"}, ins_pc, 32'd0);
        check_output({tag, "_req_addr"}, imem_req_addr, RESET_PC);
    endtask

    // Memory model: in-order responses after a fixed latency, no backpressure.
    always @(negedge clk) begin
        if (rst) begin
            mem_q.delete();
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
            if (mem_q.size() > 0 && mem_q[0].due == cyc + 1) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = mem_word(mem_q[0].addr);
                void'(mem_q.pop_front());
            end
            if (imem_req_valid && imem_req_ready) begin
                mem_q.push_back('{addr: imem_req_addr, due: cyc + 1 + lat});
                fire_count++;
                last_fire_addr = imem_req_addr;
            end
        end
    end

    // Monitor: every instruction handed to decode must be the next expected one.
    always @(negedge clk) begin
        if (!rst && ins_valid && ins_ready && !redirect_valid) begin
            pop_cycles.push_back(cyc + 1);
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("[TB] FAIL unexpected_ins: got pc %h ins %h, expected none", ins_pc, ins);
            end else begin
                exp_ins_t e;
                e = sb.pop_front();
                check_output("ins_pc", ins_pc, e.pc);
                check_output("ins", ins, e.data);
            end
        end
    end

    initial begin
        int f0;
        n_checks       = 0;
        n_fail         = 0;
        cyc            = 0;
        fire_count     = 0;
        last_fire_addr = '0;
        lat            = 1;
        rst            = 1'b1;
        imem_req_ready = 1'b0;
        ins_ready      = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;

        #1;
        check_reset_outputs("reset");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        $display("[TB] basic stream, 1-cycle memory");
        pop_cycles.delete();
        expect_ins(32'h0);
        expect_ins(32'h4);
        expect_ins(32'h8);
        apply_stimulus(1'b1, 1'b1, 1);
        run_until_fires(3, "stream_fetches");
        imem_req_ready = 1'b0;
        wait_cycles(5);
        check_output("stream_pops", pop_cycles.size(), 32'd3);
        if (pop_cycles.size() >= 3) begin
            check_output("stream_gap0", pop_cycles[1] - pop_cycles[0], 32'd1);
            check_output("stream_gap1", pop_cycles[2] - pop_cycles[1], 32'd1);
        end
        check_output("stream_next_addr", imem_req_addr, 32'hC);

        $display("[TB] decode stall fills the buffer");
        f0 = fire_count;
        expect_ins(32'hC);
        expect_ins(32'h10);
        apply_stimulus(1'b1, 1'b0, 1);
        wait_cycles(10);
        check_output("stall_fetch_count", fire_count - f0, DEPTH);
        check_output("stall_req_valid", {31'd0, imem_req_valid}, 32'd0);
        check_output("stall_ins_valid", {31'd0, ins_valid}, 32'd1);
        check_output("stall_head_pc", ins_pc, 32'hC);
        apply_stimulus(1'b0, 1'b1, 1);
        wait_cycles(4);

        $display("[TB] redirect with two fetches in flight, 3-cycle memory");
        expect_ins(32'h100);
        apply_stimulus(1'b1, 1'b1, 3);
        run_until_fires(fire_count + 2, "flush_setup_fetches");
        check_output("flush_outstanding_stall", {31'd0, imem_req_valid}, 32'd0);
        f0 = fire_count;
        pulse_redirect(32'h0000_0103);
        check_output("redirect_aligned_addr", imem_req_addr, 32'h100);
        check_output("flush_no_req", {31'd0, imem_req_valid}, 32'd0);
        run_until_fires(f0 + 1, "post_flush_fetch");
        imem_req_ready = 1'b0;
        check_output("post_flush_fire_addr", last_fire_addr, 32'h100);
        wait_cycles(6);

        $display("[TB] PC wrap at top of address space");
        expect_ins(32'hFFFF_FFFC);
        apply_stimulus(1'b0, 1'b1, 1);
        pulse_redirect(32'hFFFF_FFFC);
        imem_req_ready = 1'b1;
        run_until_fires(fire_count + 1, "wrap_fetch");
        imem_req_ready = 1'b0;
        check_output("wrap_fire_addr", last_fire_addr, 32'hFFFF_FFFC);
        check_output("wrap_next_addr", imem_req_addr, 32'h0);
        wait_cycles(4);

        $display("[TB] redirect with simultaneous decode pop");
        apply_stimulus(1'b0, 1'b0, 3);
        pulse_redirect(32'h200);
        imem_req_ready = 1'b1;
        run_until_fires(fire_count + 1, "pop_redirect_fetch");
        imem_req_ready = 1'b0;
        wait_cycles(5);
        check_output("buffered_ins_valid", {31'd0, ins_valid}, 32'd1);
        check_output("buffered_ins_pc", ins_pc, 32'h200);
        check_output("buffered_ins", ins, mem_word(32'h200));
        ins_ready = 1'b1;
        pulse_redirect(32'h300);
        ins_ready = 1'b0;
        check_output("redirect_clears_buffer", {31'd0, ins_valid}, 32'd0);
        check_output("redirect_clears_ins", ins, NOP);

        $display("[TB] asynchronous reset during flush");
        imem_req_ready = 1'b1;
        run_until_fires(fire_count + 2, "reset_setup_fetches");
        imem_req_ready = 1'b0;
        pulse_redirect(32'h400);
        check_output("flush_pc_loaded", imem_req_addr, 32'h400);
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("async_reset");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        wait_cycles(2);

        check_output("scoreboard_drained", sb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
